// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size codes, FSM states and byte-lane geometry for the load/store unit.
package lsu_pkg;
    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } lsu_state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: little-endian lane extract/extend for loads and lane merge for sub-word stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);
    logic [BYTE_W-1:0] b;
    logic [HALF_W-1:0] h;
    always_comb begin
        b = word_i[{off_i, 3'b000} +: BYTE_W];
        h = word_i[{off_i[1], 4'b0000} +: HALF_W];
        load_o = size_i == SIZE_BYTE ? {{24{~unsigned_i & b[7]}}, b}
               : size_i == SIZE_HALF ? {{16{~unsigned_i & h[15]}}, h}
               : word_i;
        merge_o = word_i;
        if (size_i == SIZE_BYTE)
            merge_o[{off_i, 3'b000} +: BYTE_W] = wdata_i[BYTE_W-1:0];
        else if (size_i == SIZE_HALF)
            merge_o[{off_i[1], 4'b0000} +: HALF_W] = wdata_i[HALF_W-1:0];
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: data-memory initiator, one request at a time, sub-word stores as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int MEM_WORDS  = 64,
    parameter int RD_LATENCY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);
    lsu_state_t state_q, state_d;
    logic write_q, write_d, uns_q, uns_d, err_q, err_d, bad;
    logic [1:0] size_q, size_d, cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, load_data, merge_data;

    lsu_align u_align (
        .size_i    (size_q),
        .unsigned_i(uns_q),
        .off_i     (addr_q[1:0]),
        .word_i    (mem_read_data),
        .wdata_i   (wdata_q),
        .load_o    (load_data),
        .merge_o   (merge_data)
    );

    assign bad = size_q == SIZE_ILLEGAL || (size_q == SIZE_HALF && addr_q[0])
              || (size_q == SIZE_WORD && |addr_q[1:0]) || (addr_q >> 2) >= ADDR_W'(MEM_WORDS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        uns_d   = uns_q;
        err_d   = err_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: if (req_valid) begin
                write_d = req_write;
                size_d  = req_size;
                uns_d   = req_unsigned;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                err_d   = bad;
                cnt_d   = '0;
                rdata_d = bad ? '0 : rdata_q;
                state_d = bad ? ST_RESP : (write_q && size_q == SIZE_WORD) ? ST_WRITE : ST_READ;
            end
            // Read data is only trusted once the latency count has elapsed.
            ST_READ: if (cnt_q == 2'(RD_LATENCY)) begin
                wdata_d = write_q ? merge_data : wdata_q;
                rdata_d = write_q ? rdata_q : load_data;
                state_d = write_q ? ST_WRITE : ST_RESP;
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
            ST_WRITE: begin
                rdata_d = '0;
                state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are forced low while rst is held so an abort drops strobes immediately.
    assign req_ready      = !rst && state_q == ST_IDLE;
    assign mem_read       = !rst && state_q == ST_READ;
    assign mem_write      = !rst && state_q == ST_WRITE;
    assign resp_valid     = !rst && state_q == ST_RESP;
    assign resp_error     = resp_valid && err_q;
    assign resp_rdata     = rst ? '0 : rdata_q;
    assign mem_address    = (mem_read || mem_write) ? addr_q >> 2 : '0;
    assign mem_write_data = mem_write ? wdata_q : '0;
endmodule
